// File: rtl/mem_loader.sv
// mem_loader: bus initiator that fills program RAM from the board switches
// while the CPU is halted. Each debounced A1 press writes byte D to the
// next RAM address and advances the load pointer.
// Build option: define LOADER_VERIFY_EN to add the RD/CHK readback states
// and a functional sticky err flag; otherwise read/err are tied low.
module mem_loader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int DEB_CYCLES = 4,
    parameter int READ_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              A1,
    input  logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              write,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        ptr
);

    localparam int             DBW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_CYCLES - 1);
    localparam logic [7:0]     PTR_LAST = 8'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CHK,
        S_FULL
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_a1_s1;
    logic              r_a1_s2;
    logic              r_a1_deb;
    logic [DBW-1:0]    r_deb_cnt;
    logic              r_pulse;
    logic [7:0]        r_ptr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_done;
    logic              w_last;
    logic              w_commit;

    assign w_last = (r_ptr == PTR_LAST);

    // Synchronise A1, require DEB_CYCLES of stable level, pulse on the accepted rising edge
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a1_s1   <= 1'b0;
            r_a1_s2   <= 1'b0;
            r_a1_deb  <= 1'b0;
            r_deb_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_a1_s1 <= A1;
            r_a1_s2 <= r_a1_s1;
            r_pulse <= 1'b0;
            if (r_a1_s2 == r_a1_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_a1_deb  <= r_a1_s2;
                r_deb_cnt <= '0;
                r_pulse   <= r_a1_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    localparam int             RDW     = $clog2(READ_LAT + 1);
    localparam logic [RDW-1:0] RD_LAST = RDW'(READ_LAT - 1);

    logic [RDW-1:0] r_rd_cnt;
    logic           r_err;

    // The byte is counted only once its readback has been checked
    assign w_commit = (r_state == S_CHK);
    assign err      = r_err;

    // Count read-latency cycles spent in RD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt <= '0;
        end else if (r_state == S_RD) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end else begin
            r_rd_cnt <= '0;
        end
    end

    // Sticky readback mismatch flag, cleared only by clr or reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (en && clr) begin
            r_err <= 1'b0;
        end else if (en && r_state == S_CHK && data_in != r_data_out) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_data_in;

    // Without readback the byte is counted as soon as it is written
    assign w_commit         = (r_state == S_WR);
    assign err              = 1'b0;
    assign w_unused_data_in = ^data_in;
`endif

    // FSM state register; reset drops write/read asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; en low or clr forces IDLE
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        write  = 1'b0;
        read   = 1'b0;
        busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // A loader that filled up and was then disabled returns to FULL
                if (r_done) begin
                    w_next = S_FULL;
                end else if (r_pulse) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                write = 1'b1;
`ifdef LOADER_VERIFY_EN
                w_next = S_RD;
`else
                w_next = w_last ? S_FULL : S_IDLE;
`endif
            end
            S_RD: begin
`ifdef LOADER_VERIFY_EN
                read = 1'b1;
                if (r_rd_cnt == RD_LAST) begin
                    w_next = S_CHK;
                end
`else
                w_next = S_IDLE;
`endif
            end
            S_CHK: begin
                w_next = w_last ? S_FULL : S_IDLE;
            end
            S_FULL: begin
                busy   = 1'b0;
                w_next = S_FULL;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (!en || clr) begin
            w_next = S_IDLE;
        end
    end

    // Load pointer, captured byte and done flag; clr beats a same-cycle pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= 8'd0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else if (en) begin
            if (clr) begin
                r_ptr  <= 8'd0;
                r_done <= 1'b0;
            end else begin
                if (r_state == S_IDLE && !r_done && r_pulse) begin
                    r_data_out <= D;
                end
                if (w_commit) begin
                    if (w_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + 8'd1;
                    end
                end
            end
        end
    end

    assign ptr      = r_ptr;
    assign addr     = ADDR_W'(r_ptr);
    assign data_out = r_data_out;
    assign done     = r_done;

endmodule
